// File: rtl/dff_rr_arbiter_if.sv
// Handshake bundle between the requesters/consumer and the round-robin capture arbiter.
// The slave modport is the arbiter's view of the bus; the master modport is the environment's view.
interface dff_rr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) ();
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] din;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      dout;
   logic [IDW-1:0]        dout_id;
   logic                  dout_valid;
   logic                  dout_ready;

   modport slave (
      input  req, din, dout_ready,
      output gnt, dout, dout_id, dout_valid
   );

   modport master (
      output req, din, dout_ready,
      input  gnt, dout, dout_id, dout_valid
   );
endinterface

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter feeding one shared capture register with a valid/ready output.
// Grant is combinational from req/dout_ready/pointer; din only reaches outputs through the register.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | capture register holds no unconsumed word
// FULL  | capture register holds a word awaiting dout_ready
module dff_rr_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   dff_rr_arbiter_if.slave        bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [IDW-1:0]   dout_id_q, dout_id_d;
   logic [IDW-1:0]   ptr_q, ptr_d;

   logic             slot_free;
   logic             found;
   logic [NREQ-1:0]  gnt_c;
   logic [IDW-1:0]   gnt_idx;
   int               idx;

   assign slot_free = (state_q == EMPTY) || bus.dout_ready;

   // Search from the pointer upward, wrapping modulo NREQ; first set request wins.
   always_comb begin
      gnt_c   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (rst && slot_free) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
               found       = 1'b1;
               gnt_c[idx]  = 1'b1;
               gnt_idx     = IDW'(idx);
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      dout_id_d = dout_id_q;
      ptr_d     = ptr_q;
      if (found) begin
         state_d   = FULL;
         dout_d    = bus.din[int'(gnt_idx)*WIDTH +: WIDTH];
         dout_id_d = gnt_idx;
         ptr_d     = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      end else if (slot_free) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= EMPTY;
         dout_q    <= '0;
         dout_id_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         dout_q    <= dout_d;
         dout_id_q <= dout_id_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.gnt        = gnt_c;
   assign bus.dout       = dout_q;
   assign bus.dout_id    = dout_id_q;
   assign bus.dout_valid = (state_q == FULL);

endmodule
